// File: rtl/sequence_detector_moore.sv
// Moore-style serial pattern detector for the bit sequence 1011, oldest bit first.
// detector_out is decoded purely from the state register, so there is no
// combinational path from sequence_in to the flag.
//
// state  | meaning
// -------+-------------------------------------------
// IDLE   | no useful prefix seen
// S1     | last bit seen was 1
// S10    | last bits seen were 10
// S101   | last bits seen were 101
// DET    | 1011 just completed; detector_out is high
//
// OVERLAP=1 lets the tail of a hit seed the next match (DET -> S10 on 0).
// OVERLAP=0 restarts from scratch (DET -> IDLE on 0). In both modes a 1
// after DET goes to S1, because a lone 1 is a fresh prefix either way.

module sequence_detector_moore #(
    parameter bit OVERLAP = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic sequence_in,
    output logic detector_out
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_1    = 3'd1;
    localparam logic [2:0] S_10   = 3'd2;
    localparam logic [2:0] S_101  = 3'd3;
    localparam logic [2:0] S_DET  = 3'd4;

    logic [2:0] r_state;
    logic [2:0] w_next_state;

    // State register: asynchronous reset forces IDLE immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic. An X on sequence_in takes the 0 branch rather than
    // producing an X state, and any unused encoding falls back to IDLE.
    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (sequence_in) w_next_state = S_1;
                else             w_next_state = S_IDLE;
            end
            S_1: begin
                if (sequence_in) w_next_state = S_1;
                else             w_next_state = S_10;
            end
            S_10: begin
                if (sequence_in) w_next_state = S_101;
                else             w_next_state = S_IDLE;
            end
            S_101: begin
                if (sequence_in) w_next_state = S_DET;
                else             w_next_state = S_10;
            end
            S_DET: begin
                if (sequence_in)  w_next_state = S_1;
                else if (OVERLAP) w_next_state = S_10;
                else              w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Moore output: decoded from the registered state only.
    always_comb begin
        detector_out = (r_state == S_DET);
    end

endmodule

// File: tb/tb_sequence_detector_moore.sv
// Self-checking bench for sequence_detector_moore. Two instances share the
// stimulus: one with OVERLAP=1 and one with OVERLAP=0. The reference model
// keeps the last four bits since reset and the position of the last
// non-overlapping hit, and predicts the flag one cycle after each bit.

module tb_sequence_detector_moore;

    logic clock;
    logic reset;
    logic sequence_in;
    logic det_ovl;
    logic det_non;

    int total;
    int bad;

    logic [3:0] m_hist;
    int         m_cnt;
    int         m_last_non;

    sequence_detector_moore #(.OVERLAP(1'b1)) dut_ovl (
        .clock       (clock),
        .reset       (reset),
        .sequence_in (sequence_in),
        .detector_out(det_ovl)
    );

    sequence_detector_moore #(.OVERLAP(1'b0)) dut_non (
        .clock       (clock),
        .reset       (reset),
        .sequence_in (sequence_in),
        .detector_out(det_non)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic model_clear();
        m_hist     = 4'b0000;
        m_cnt      = 0;
        m_last_non = -100;
    endtask

    // Drive one bit, let it be sampled, then compare both flags to the model.
    task automatic step(input logic b, input string tag, output logic e_o, output logic e_n);
        sequence_in = b;
        @(posedge clock);
        #1;
        m_hist = {m_hist[2:0], b};
        m_cnt++;
        e_o = (m_cnt >= 4) && (m_hist == 4'b1011);
        e_n = e_o && ((m_cnt - m_last_non) >= 4);
        if (e_n) m_last_non = m_cnt;
        total++;
        if (det_ovl !== e_o) begin
            bad++;
            $display("FAIL %s ovl bit%0d: got=%b want=%b", tag, m_cnt, det_ovl, e_o);
        end
        total++;
        if (det_non !== e_n) begin
            bad++;
            $display("FAIL %s non bit%0d: got=%b want=%b", tag, m_cnt, det_non, e_n);
        end
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        sequence_in = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_clear();
    endtask

    // Fixed-time scenario: release at 30 ns, pattern inputs from 70 ns.
    task automatic test_basic_hit();
        logic exp;
        int   t;
        for (int c = 0; c < 20; c++) begin
            t = c * 10;
            reset = (t >= 30);
            sequence_in = (t == 70) || (t >= 90 && t < 110) || (t >= 130 && t < 150);
            #6;
            exp = ((t + 5) == 105);
            total++;
            if (det_ovl !== exp) begin
                bad++;
                $display("FAIL basic_hit ovl t=%0d: got=%b want=%b", t + 6, det_ovl, exp);
            end
            total++;
            if (det_non !== exp) begin
                bad++;
                $display("FAIL basic_hit non t=%0d: got=%b want=%b", t + 6, det_non, exp);
            end
            #4;
        end
    endtask

    task automatic test_reset();
        logic eo, en;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sequence_in = 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
            total++;
            if (det_ovl !== 1'b0 || det_non !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold cyc%0d: got=%b%b want=00", i, det_ovl, det_non);
            end
        end
        reset = 1'b1;
        model_clear();
        step(1'b1, "to_det", eo, en);
        step(1'b0, "to_det", eo, en);
        step(1'b1, "to_det", eo, en);
        step(1'b1, "to_det", eo, en);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (det_ovl !== 1'b0 || det_non !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_in_det: got=%b%b want=00", det_ovl, det_non);
        end
        @(posedge clock);
        #3;
        reset = 1'b1;
        model_clear();
        step(1'b1, "mid_pat", eo, en);
        step(1'b0, "mid_pat", eo, en);
        step(1'b1, "mid_pat", eo, en);
        #2;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        model_clear();
        step(1'b1, "after_mid_reset", eo, en);
        total++;
        if (eo !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_model: got=%b want=0", eo);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] stream;
        logic eo, en;
        int   n_o, n_n;
        stream = 7'b1011011;
        reset_pulse();
        n_o = 0;
        n_n = 0;
        for (int i = 6; i >= 0; i--) begin
            step(stream[i], "overlap", eo, en);
            if (det_ovl === 1'b1) n_o++;
            if (det_non === 1'b1) n_n++;
        end
        total++;
        if (n_o != 2) begin
            bad++;
            $display("FAIL overlap_count ovl: got=%0d want=2", n_o);
        end
        total++;
        if (n_n != 1) begin
            bad++;
            $display("FAIL overlap_count non: got=%0d want=1", n_n);
        end
    endtask

    task automatic test_near_miss();
        logic [3:0] pats [4];
        logic [3:0] p;
        logic eo, en;
        int   n;
        pats[0] = 4'b1001;
        pats[1] = 4'b1010;
        pats[2] = 4'b0111;
        pats[3] = 4'b1101;
        reset_pulse();
        for (int k = 0; k < 4; k++) begin
            p = pats[k];
            n = 0;
            for (int i = 0; i < 4; i++) step(1'b0, "nm_flush", eo, en);
            for (int i = 3; i >= 0; i--) begin
                step(p[i], "near_miss", eo, en);
                if (det_ovl === 1'b1 || det_non === 1'b1) n++;
            end
            total++;
            if (n != 0) begin
                bad++;
                $display("FAIL near_miss pat%0d: got=%0d pulses want=0", k, n);
            end
        end
        n = 0;
        step(1'b1, "nm_tail", eo, en);
        if (det_ovl === 1'b1) n++;
        step(1'b1, "nm_tail", eo, en);
        total++;
        if (n != 1) begin
            bad++;
            $display("FAIL near_miss_tail: got=%0d pulses want=1", n);
        end
    endtask

    task automatic test_prefix_recovery();
        logic [5:0] stream;
        logic eo, en;
        int   n;
        stream = 6'b111011;
        reset_pulse();
        n = 0;
        for (int i = 5; i >= 0; i--) begin
            step(stream[i], "prefix", eo, en);
            if (det_ovl === 1'b1) n++;
        end
        total++;
        if (n != 1 || det_ovl !== 1'b1) begin
            bad++;
            $display("FAIL prefix_recovery: got=%0d pulses last=%b want=1 last=1", n, det_ovl);
        end
    endtask

    task automatic test_random_stream();
        logic eo, en;
        logic prev;
        reset_pulse();
        prev = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step(1'($urandom_range(0, 1)), "random", eo, en);
            if (prev && det_ovl) begin
                total++;
                bad++;
                $display("FAIL back_to_back bit%0d: got=11 want=not both", i);
            end
            prev = det_ovl;
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0;
        sequence_in = 1'b0;
        model_clear();
        test_basic_hit();
        test_reset();
        test_overlap();
        test_near_miss();
        test_prefix_recovery();
        test_random_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
